// File: rtl/fifo_word_packer_if.sv
// Bundle between the word packer, the read side of the byte FIFO and the
// downstream valid/ready word stream. master = packer, slave = its environment.
interface fifo_word_packer_if #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4
);
    localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;

    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic [IN_WIDTH-1:0]  fifo_dout;
    logic                 flush;
    logic                 m_valid;
    logic                 m_ready;
    logic [OUT_WIDTH-1:0] m_data;
    logic [RATIO-1:0]     m_keep;
    logic                 busy;

    modport master (
        input  fifo_empty, fifo_dout, flush, m_ready,
        output fifo_rd_en, m_valid, m_data, m_keep, busy
    );

    modport slave (
        output fifo_empty, fifo_dout, flush, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_keep, busy
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops entries from a one-cycle-latency FIFO and packs RATIO of them little-endian
// into one output word on a valid/ready stream; flush emits a partial word with keep.
module fifo_word_packer #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4
) (
    input  logic               clk,
    input  logic               reset,
    fifo_word_packer_if.master bus
);
    localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int unsigned IDX_W     = $clog2(RATIO);
    localparam int unsigned CNT_W     = IDX_W + 1;

    logic [RATIO-1:0][IN_WIDTH-1:0] lanes_q, lanes_n;
    logic [CNT_W-1:0]               lane_cnt_q, lane_cnt_n;
    logic [CNT_W-1:0]               cnt_inc;
    logic                           pending_q;
    logic                           flush_req_q, flush_req_n;
    logic                           m_valid_q, m_valid_n;
    logic [OUT_WIDTH-1:0]           m_data_q, m_data_n;
    logic [RATIO-1:0]               m_keep_q, m_keep_n;
    logic [RATIO-1:0]               cnt_keep;
    logic                           busy_q, busy_n;
    logic                           rd_en_c;
    logic                           out_free_c;
    logic                           emit_c;

    // Pop only while assembly has room for the pop plus any one already in flight.
    assign rd_en_c = !reset && !bus.fifo_empty && !flush_req_q
                   && ((lane_cnt_q + CNT_W'(pending_q)) < CNT_W'(RATIO));

    assign out_free_c = !m_valid_q || bus.m_ready;

    // Move assembly to output: a held full word, or a partial word on flush service.
    assign emit_c = !pending_q && out_free_c
                  && ((lane_cnt_q == CNT_W'(RATIO)) || (flush_req_q && (lane_cnt_q != '0)));

    always_comb begin
        cnt_keep = '0;
        for (int k = 0; k < int'(RATIO); k++) begin
            cnt_keep[k] = (CNT_W'(k) < lane_cnt_q);
        end
    end

    always_comb begin
        lanes_n     = lanes_q;
        lane_cnt_n  = lane_cnt_q;
        flush_req_n = flush_req_q;
        m_valid_n   = m_valid_q && !bus.m_ready;
        m_data_n    = m_data_q;
        m_keep_n    = m_keep_q;
        cnt_inc     = lane_cnt_q + CNT_W'(1);

        if (pending_q) begin
            lanes_n[lane_cnt_q[IDX_W-1:0]] = bus.fifo_dout;
            if ((cnt_inc == CNT_W'(RATIO)) && out_free_c) begin
                m_valid_n  = 1'b1;
                m_data_n   = lanes_n;
                m_keep_n   = '1;
                lanes_n    = '0;
                lane_cnt_n = '0;
            end else begin
                lane_cnt_n = cnt_inc;
            end
        end else if (emit_c) begin
            m_valid_n  = 1'b1;
            m_data_n   = lanes_q;
            m_keep_n   = cnt_keep;
            lanes_n    = '0;
            lane_cnt_n = '0;
        end

        // Service clears the request; a pulse landing on a pending request is absorbed.
        if (flush_req_q && !pending_q && out_free_c) begin
            flush_req_n = 1'b0;
        end else if (bus.flush) begin
            flush_req_n = 1'b1;
        end

        busy_n = (lane_cnt_n != '0) || rd_en_c || flush_req_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lanes_q     <= '0;
            lane_cnt_q  <= '0;
            pending_q   <= 1'b0;
            flush_req_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            lanes_q     <= lanes_n;
            lane_cnt_q  <= lane_cnt_n;
            pending_q   <= rd_en_c;
            flush_req_q <= flush_req_n;
            m_valid_q   <= m_valid_n;
            m_data_q    <= m_data_n;
            m_keep_q    <= m_keep_n;
            busy_q      <= busy_n;
        end
    end

    assign bus.fifo_rd_en = rd_en_c;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_keep     = m_keep_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: byte FIFO model, table vectors, corner-case
// sequences and random traffic checked against a byte-chunking reference model.
module tb_fifo_word_packer;
    localparam int unsigned IN_WIDTH = 8;
    localparam int unsigned RATIO    = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        int          pops;
    } word_t;

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic        fl;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    fifo_word_packer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) bus ();

    fifo_word_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  fifo_q[$];
    logic [7:0]  cur[$];
    word_t       exp_q[$];
    word_t       got_q[$];
    int          pops_seen = 0;
    int          flush_at_pop = -1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;
    logic        pop_last;
    logic        valid_last;
    vec_t        tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: bytes leave the FIFO in order and are grouped RATIO at a time;
    // a flush cuts whatever has been popped so far into a partial word.
    task automatic model_emit();
        word_t w;
        w.data = '0;
        for (int k = 0; k < cur.size(); k++) w.data[k*8 +: 8] = cur[k];
        w.keep = 4'((1 << cur.size()) - 1);
        w.pops = 0;
        exp_q.push_back(w);
        cur.delete();
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic rdy, input logic fl);
        logic [7:0] b;
        logic       pop;
        logic       flush_now;
        word_t      w, e;
        bus.m_ready    = rdy;
        bus.flush      = fl;
        bus.fifo_empty = (fifo_q.size() == 0);
        #1;
        pop        = bus.fifo_rd_en;
        pop_last   = pop;
        valid_last = bus.m_valid;
        b          = 8'h00;
        flush_now  = fl;
        if (bus.fifo_empty) chk("pop_on_empty", 64'(pop), 64'd0);
        if (prev_stall) begin
            chk("hold_data", 64'(bus.m_data), 64'(prev_data));
            chk("hold_keep", 64'(bus.m_keep), 64'(prev_keep));
        end
        if (bus.m_valid && rdy) begin
            w.data = bus.m_data;
            w.keep = bus.m_keep;
            w.pops = pops_seen;
            got_q.push_back(w);
            chk("word_available", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("word_data", 64'(bus.m_data), 64'(e.data));
                chk("word_keep", 64'(bus.m_keep), 64'(e.keep));
            end
        end
        prev_stall = bus.m_valid && !rdy;
        prev_data  = bus.m_data;
        prev_keep  = bus.m_keep;
        if (pop && (pops_seen + 1 == flush_at_pop)) begin
            bus.flush = 1'b1;
            flush_now = 1'b1;
        end
        if (pop && fifo_q.size() > 0) begin
            b = fifo_q.pop_front();
            pops_seen++;
            cur.push_back(b);
            if (cur.size() == RATIO) model_emit();
        end
        if (flush_now && cur.size() > 0) model_emit();
        @(posedge clk);
        #1;
        if (pop) bus.fifo_dout = b;
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(rdy, 1'b0);
    endtask

    task automatic got_chk(input string name, input int idx, input logic [31:0] d, input logic [3:0] k);
        word_t w;
        if (got_q.size() > idx) w = got_q[idx];
        else begin
            w.data = 32'hDEAD_BEEF;
            w.keep = 4'h0;
            w.pops = -1;
        end
        chk({name, "_data"}, 64'(w.data), 64'(d));
        chk({name, "_keep"}, 64'(w.keep), 64'(k));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_en"},   64'(bus.fifo_rd_en), 64'd0);
        chk({tag, "_m_valid"}, 64'(bus.m_valid),    64'd0);
        chk({tag, "_m_data"},  64'(bus.m_data),     64'd0);
        chk({tag, "_m_keep"},  64'(bus.m_keep),     64'd0);
        chk({tag, "_busy"},    64'(bus.busy),       64'd0);
    endtask

    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        fifo_q.delete();
        cur.delete();
        exp_q.delete();
        got_q.delete();
        prev_stall     = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.flush      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     base, npops, first, last, nval, vfirst, t;
        logic   flushed, do_fl;

        tbl[0] = '{32'h44332211, 4, 1'b0, 32'h44332211, 4'hF};
        tbl[1] = '{32'h0000BBAA, 2, 1'b1, 32'h0000BBAA, 4'h3};
        tbl[2] = '{32'h0000005A, 1, 1'b1, 32'h0000005A, 4'h1};
        tbl[3] = '{32'h00030201, 3, 1'b1, 32'h00030201, 4'h7};
        tbl[4] = '{32'hEFBEADDE, 4, 1'b0, 32'hEFBEADDE, 4'hF};
        tbl[5] = '{32'h13121110, 4, 1'b1, 32'h13121110, 4'hF};

        reset          = 1'b1;
        bus.fifo_empty = 1'b0;
        bus.fifo_dout  = 8'h00;
        bus.flush      = 1'b0;
        bus.m_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        bus.fifo_empty = 1'b1;
        reset          = 1'b0;

        // Table-driven single-word vectors.
        for (int r = 0; r < 6; r++) begin
            got_q.delete();
            for (int k = 0; k < tbl[r].n; k++) fifo_q.push_back(tbl[r].bytes[k*8 +: 8]);
            run(10, 1'b1);
            if (tbl[r].fl) cycle(1'b1, 1'b1);
            run(8, 1'b1);
            chk($sformatf("vec%0d_count", r), 64'(got_q.size()), 64'd1);
            got_chk($sformatf("vec%0d", r), 0, tbl[r].exp_data, tbl[r].exp_keep);
            chk($sformatf("vec%0d_busy", r), 64'(bus.busy), 64'd0);
        end

        // Four back-to-back pops, word valid one cycle, two cycles after last pop.
        got_q.delete();
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        npops = 0; first = -1; last = -1; nval = 0; vfirst = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0);
            if (pop_last) begin
                npops++;
                if (first < 0) first = i;
                last = i;
            end
            if (valid_last) begin
                nval++;
                if (vfirst < 0) vfirst = i;
            end
        end
        chk("seq1_pops", 64'(npops), 64'd4);
        chk("seq1_pop_span", 64'(last - first), 64'd3);
        chk("seq1_valid_cycles", 64'(nval), 64'd1);
        chk("seq1_word_latency", 64'(vfirst - last), 64'd2);
        got_chk("seq1", 0, 32'h44332211, 4'hF);

        // Backpressure: storage limit of one output word plus one assembled word.
        got_q.delete();
        base = pops_seen;
        for (int k = 1; k <= 12; k++) fifo_q.push_back(8'(k));
        run(20, 1'b0);
        chk("seq2_stall_pops", 64'(pops_seen - base), 64'd8);
        chk("seq2_stall_valid", 64'(bus.m_valid), 64'd1);
        chk("seq2_stall_data", 64'(bus.m_data), 64'h04030201);
        run(25, 1'b1);
        chk("seq2_count", 64'(got_q.size()), 64'd3);
        got_chk("seq2_w0", 0, 32'h04030201, 4'hF);
        got_chk("seq2_w1", 1, 32'h08070605, 4'hF);
        got_chk("seq2_w2", 2, 32'h0C0B0A09, 4'hF);

        // Partial flush followed by a full word packed from lane 0.
        got_q.delete();
        fifo_q = '{8'hAA, 8'hBB};
        run(5, 1'b1);
        cycle(1'b1, 1'b1);
        run(5, 1'b1);
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run(10, 1'b1);
        got_chk("seq3_partial", 0, 32'h0000BBAA, 4'h3);
        got_chk("seq3_full", 1, 32'h04030201, 4'hF);

        // Flush with nothing held.
        nval = 0;
        cycle(1'b1, 1'b1);
        nval += int'(valid_last);
        chk("seq4_busy_set", 64'(bus.busy), 64'd1);
        cycle(1'b1, 1'b0);
        nval += int'(valid_last);
        chk("seq4_busy_clear", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            nval += int'(valid_last);
        end
        chk("seq4_no_valid", 64'(nval), 64'd0);

        // Flush in the same cycle as the third pop; pops stop until it is serviced.
        got_q.delete();
        base = pops_seen;
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        flush_at_pop = base + 3;
        run(15, 1'b1);
        flush_at_pop = -1;
        got_chk("seq5_partial", 0, 32'h00332211, 4'h7);
        chk("seq5_pops_before_word", 64'((got_q.size() > 0) ? got_q[0].pops - base : -1), 64'd3);
        cycle(1'b1, 1'b1);
        run(6, 1'b1);
        got_chk("seq5_tail", 1, 32'h00000044, 4'h1);

        // Reset with a word in the output register and two bytes in assembly.
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA1, 8'hA2};
        run(12, 1'b0);
        chk("seq6_pre_valid", 64'(bus.m_valid), 64'd1);
        chk("seq6_pre_busy", 64'(bus.busy), 64'd1);
        mid_reset();
        fifo_q = '{8'h55, 8'h66, 8'h77, 8'h88};
        run(12, 1'b1);
        chk("seq6_count", 64'(got_q.size()), 64'd1);
        got_chk("seq6_after", 0, 32'h88776655, 4'hF);

        // Random traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            if (fifo_q.size() < 16 && $urandom_range(0, 9) < 5) fifo_q.push_back(8'($urandom));
            cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 99) < 3));
        end

        flushed = 1'b0;
        t = 0;
        while (t < 400 && !(flushed && exp_q.size() == 0 && !bus.busy && !bus.m_valid)) begin
            do_fl = !flushed && (fifo_q.size() == 0);
            cycle(1'b1, do_fl);
            if (do_fl) flushed = 1'b1;
            t++;
        end
        chk("drain_words_left", 64'(exp_q.size()), 64'd0);
        chk("drain_model_bytes", 64'(cur.size()), 64'd0);
        chk("drain_busy", 64'(bus.busy), 64'd0);
        chk("drain_valid", 64'(bus.m_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
